// File: rtl/ssy_requester.sv
// Initiator-side requester for the ssy request/grant handshake: queues jobs as a
// pending count, arbitrates for each one with timeout/backoff/retry, then holds ownership.
module ssy_requester #(
    parameter int QDEPTH    = 4,
    parameter int HOLD      = 2,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3,
    parameter int CW        = 8,
    localparam int PW       = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic          idle,
    input  logic          granted,
    output logic          request,
    output logic          owned,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] pend,
    output logic [CW-1:0] grant_cnt
);
    localparam int WW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_OWN, S_BACKOFF} state_t;

    state_t        state_reg;
    logic [WW-1:0] wait_cnt_reg;
    logic [RW-1:0] retry_cnt_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic [PW-1:0] pend_reg;
    logic [CW-1:0] grant_cnt_reg;
    logic          done_reg;
    logic          err_reg;

    logic accept;
    logic timeout_hit;
    logic last_try;
    logic retire;

    always_comb begin
        accept      = job_valid && job_ready;
        timeout_hit = (wait_cnt_reg == WW'(TIMEOUT - 1));
        last_try    = (retry_cnt_reg == RW'(MAX_RETRY - 1));
        // A job leaves the queue either when it is granted or when its last attempt times out.
        retire      = (state_reg == S_ARB) && (granted || (timeout_hit && last_try));
    end

    assign job_ready = (pend_reg < PW'(QDEPTH));
    assign request   = (state_reg == S_ARB) && idle;
    assign owned     = (state_reg == S_OWN);
    assign done      = done_reg;
    assign err       = err_reg;
    assign pend      = pend_reg;
    assign grant_cnt = grant_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            pend_reg      <= '0;
            grant_cnt_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            if (accept && !retire) begin
                pend_reg <= pend_reg + PW'(1);
            end else if (!accept && retire) begin
                pend_reg <= pend_reg - PW'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (pend_reg != '0) begin
                        state_reg    <= S_ARB;
                        wait_cnt_reg <= '0;
                    end
                end
                S_ARB: begin
                    if (granted) begin
                        state_reg     <= S_OWN;
                        hold_cnt_reg  <= '0;
                        grant_cnt_reg <= grant_cnt_reg + CW'(1);
                        retry_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        if (last_try) begin
                            err_reg       <= 1'b1;
                            retry_cnt_reg <= '0;
                            state_reg     <= S_IDLE;
                        end else begin
                            retry_cnt_reg <= retry_cnt_reg + RW'(1);
                            wait_cnt_reg  <= '0;
                            state_reg     <= S_BACKOFF;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WW'(1);
                    end
                end
                // wait_cnt doubles as the two-cycle backoff timer.
                S_BACKOFF: begin
                    if (wait_cnt_reg == WW'(1)) begin
                        state_reg    <= S_ARB;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WW'(1);
                    end
                end
                S_OWN: begin
                    if (hold_cnt_reg == HW'(HOLD - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssy_requester.sv
// Directed + randomized bench for ssy_requester; a timestamp-based reference model
// predicts every output each cycle.
module tb_ssy_requester;
    localparam int QDEPTH    = 4;
    localparam int HOLD      = 2;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;
    localparam int CW        = 8;
    localparam int PW        = $clog2(QDEPTH + 1);
    localparam int DROP_LAT  = MAX_RETRY * TIMEOUT + 2 * (MAX_RETRY - 1);

    logic          clk = 1'b0;
    logic          reset_n, job_valid, idle, granted;
    logic          job_ready, request, owned, done, err;
    logic [PW-1:0] pend;
    logic [CW-1:0] grant_cnt;

    always #5 clk = ~clk;

    ssy_requester #(
        .QDEPTH(QDEPTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CW(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
        .idle(idle), .granted(granted), .request(request), .owned(owned),
        .done(done), .err(err), .pend(pend), .grant_cnt(grant_cnt)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: phase plus the edge at which the phase began.
    typedef enum int {MI, MA, MB, MO} mmode_t;
    mmode_t m_mode = MI;
    int cyc = 0;
    int m_pend = 0, m_grants = 0, m_attempt = 0;
    int m_arb_start = 0, m_bo_end = 0, m_own_start = 0;
    bit m_done = 0, m_err = 0;
    int done_seen = 0, err_seen = 0, last_err_edge = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int retire = 0;
        bit acc = job_valid && (m_pend < QDEPTH);
        m_done = 0;
        m_err  = 0;
        if (!reset_n) begin
            m_mode = MI; m_pend = 0; m_grants = 0; m_attempt = 0;
            return;
        end
        case (m_mode)
            MI: if (m_pend > 0) begin m_mode = MA; m_arb_start = cyc; end
            MA: begin
                if (granted) begin
                    m_mode = MO; m_own_start = cyc; retire = 1; m_grants++; m_attempt = 0;
                end else if (cyc - m_arb_start == TIMEOUT) begin
                    if (m_attempt == MAX_RETRY - 1) begin
                        m_err = 1; retire = 1; m_attempt = 0; m_mode = MI;
                    end else begin
                        m_attempt++; m_mode = MB; m_bo_end = cyc + 2;
                    end
                end
            end
            MB: if (cyc == m_bo_end) begin m_mode = MA; m_arb_start = cyc; end
            MO: if (cyc == m_own_start + HOLD) begin m_done = 1; m_mode = MI; end
            default: m_mode = MI;
        endcase
        if (acc) $display("cycle %0d: job accepted, pending %0d", cyc, m_pend + 1 - retire);
        m_pend = m_pend + int'(acc) - retire;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        chk("request", request, (m_mode == MA) && idle);
        chk("owned", owned, m_mode == MO);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("pend", pend, m_pend);
        chk("grant_cnt", grant_cnt, m_grants % (1 << CW));
        chk("job_ready", job_ready, m_pend < QDEPTH);
        if (done === 1'b1) begin done_seen++; $display("cycle %0d: job done", cyc); end
        if (err === 1'b1) begin
            err_seen++; last_err_edge = cyc;
            $display("cycle %0d: job dropped after retries", cyc);
        end
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (request !== 1'b1 && n < limit) begin tick(); n++; end
        chk("wait_request", request, 1);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin tick(); n++; end
        chk("wait_done", done, 1);
    endtask

    task automatic wait_err(input int limit);
        int n = 0;
        while (err_seen == 0 && n < limit) begin tick(); n++; end
        chk("wait_err", err_seen, 1);
    endtask

    task automatic push(input int n);
        job_valid = 1'b1;
        repeat (n) tick();
        job_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rq, oc, a;
        reset_n = 1'b0; job_valid = 1'b0; idle = 1'b1; granted = 1'b0;
        tick(); tick();
        chk("rst_ready", job_ready, 1);
        chk("rst_pend", pend, 0);
        reset_n = 1'b1;

        // Single job, grant in the third request cycle
        done_seen = 0;
        push(1);
        wait_req(10);
        rq = 0;
        for (int i = 0; i < 3; i++) begin
            if (request === 1'b1) rq++;
            if (i == 2) granted = 1'b1;
            tick();
            granted = 1'b0;
        end
        if (request === 1'b1) rq++;
        chk("s1_request_cycles", rq, 3);
        oc = 0;
        repeat (4) begin if (owned === 1'b1) oc++; tick(); end
        chk("s1_owned_cycles", oc, HOLD);
        chk("s1_done_count", done_seen, 1);
        chk("s1_grant_cnt", grant_cnt, 1);
        chk("s1_pend", pend, 0);

        // Idle gating with toggling idle
        push(1);
        wait_req(10);
        idle = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            idle = ~idle;
            #1;
            chk("idle_gate", request, idle);
            tick();
        end
        idle = 1'b1; granted = 1'b1;
        tick();
        granted = 1'b0;
        wait_done(10);

        // Queue full, then one grant, then randomized drain
        push(6);
        chk("q_pend_full", pend, QDEPTH);
        chk("q_ready_full", job_ready, 0);
        granted = 1'b1;
        tick();
        granted = 1'b0;
        chk("q_pend_after_grant", pend, QDEPTH - 1);
        chk("q_ready_after_grant", job_ready, 1);
        begin
            int n = 0;
            while ((m_pend > 0 || m_mode != MI) && n < 1500) begin
                idle    = ($urandom_range(0, 3) != 0);
                granted = (m_mode == MA) && idle && ($urandom_range(0, 5) == 0);
                tick();
                n++;
            end
            granted = 1'b0; idle = 1'b1;
            chk("drain_pend", pend, 0);
        end

        // Timeout and drop, then a granted job
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        done_seen = 0; err_seen = 0;
        push(1);
        wait_req(5);
        a = cyc;
        wait_err(100);
        chk("drop_latency", last_err_edge - a, DROP_LAT);
        chk("drop_no_done", done_seen, 0);
        chk("drop_pend", pend, 0);
        push(1);
        wait_req(5);
        granted = 1'b1; tick(); granted = 1'b0;
        wait_done(10);
        chk("after_drop_grant_cnt", grant_cnt, 1);
        chk("after_drop_done_count", done_seen, 1);

        // Grant in the last cycle of the second ARB window
        push(1);
        wait_req(5);
        repeat (TIMEOUT + 2) tick();
        chk("edge_second_window", request, 1);
        repeat (TIMEOUT - 1) tick();
        granted = 1'b1; tick(); granted = 1'b0;
        chk("edge_grant_owned", owned, 1);
        wait_done(10);
        err_seen = 0;
        push(1);
        wait_req(5);
        a = cyc;
        wait_err(100);
        chk("edge_retry_cleared", last_err_edge - a, DROP_LAT);

        // Reset during OWN with two jobs still pending
        done_seen = 0;
        push(3);
        wait_req(5);
        granted = 1'b1; tick(); granted = 1'b0;
        chk("mid_owned", owned, 1);
        chk("mid_pend", pend, 2);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("mid_request", request, 0);
        chk("mid_owned_rst", owned, 0);
        chk("mid_done", done, 0);
        chk("mid_err", err, 0);
        chk("mid_pend_rst", pend, 0);
        chk("mid_grant_cnt", grant_cnt, 0);
        chk("mid_ready", job_ready, 1);
        repeat (6) tick();
        chk("mid_no_done", done_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
